// File: rtl/stopwatch_lap_timer_pkg.sv
// ============================================================================
// Module  : stopwatch_pkg
// Brief   : Shared state enum, digit limits and 7-segment codes for the stopwatch.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } sw_state_e;

  localparam logic [3:0] D0_MAX = 4'd9;
  localparam logic [3:0] D1_MAX = 4'd9;
  localparam logic [3:0] D2_MAX = 4'd5;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] i_d);
    logic [6:0] w_s;
    case (i_d)
      4'd0:    w_s = SEG_0;
      4'd1:    w_s = SEG_1;
      4'd2:    w_s = SEG_2;
      4'd3:    w_s = SEG_3;
      4'd4:    w_s = SEG_4;
      4'd5:    w_s = SEG_5;
      4'd6:    w_s = SEG_6;
      4'd7:    w_s = SEG_7;
      4'd8:    w_s = SEG_8;
      4'd9:    w_s = SEG_9;
      default: w_s = SEG_DASH;
    endcase
    return w_s;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] i_d, input logic [3:0] i_lim);
    return (i_d > i_lim) ? i_lim : i_d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_lap_timer_if.sv
// ============================================================================
// Module  : stopwatch_lap_timer_if
// Brief   : Button inputs and display/status outputs of the stopwatch.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface stopwatch_lap_timer_if;
  logic        start_stop;
  logic        lap;
  logic        clear;
  logic        mode_down;
  logic [15:0] preset;
  logic [15:0] time_bcd;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        running;
  logic        lap_active;
  logic        overflow;
  logic        done;

  modport master (
    output start_stop, lap, clear, mode_down, preset,
    input  time_bcd, seg, dp, an, running, lap_active, overflow, done
  );

  modport slave (
    input  start_stop, lap, clear, mode_down, preset,
    output time_bcd, seg, dp, an, running, lap_active, overflow, done
  );
endinterface

`default_nettype wire

// File: rtl/stopwatch_lap_timer_seg7_mux.sv
// ============================================================================
// Module  : sw_seg7_mux
// Brief   : Free-running refresh counter driving a 4-digit multiplexed display.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sw_seg7_mux
  import stopwatch_pkg::*;
#(
  parameter int MUX_BITS = 18
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [15:0] i_digits,
  output logic      [6:0]  o_seg,
  output logic             o_dp,
  output logic      [3:0]  o_an
);

  logic [MUX_BITS-1:0] r_refresh;
  logic [1:0]          w_sel;
  logic [3:0]          w_digit;

  always_ff @(posedge clk) begin
    if (rst) r_refresh <= '0;
    else     r_refresh <= r_refresh + 1'b1;
  end

  assign w_sel = r_refresh[MUX_BITS-1 -: 2];

  always_comb begin
    w_digit = i_digits[3:0];
    o_an    = 4'b1110;
    case (w_sel)
      2'd0: begin w_digit = i_digits[3:0];   o_an = 4'b1110; end
      2'd1: begin w_digit = i_digits[7:4];   o_an = 4'b1101; end
      2'd2: begin w_digit = i_digits[11:8];  o_an = 4'b1011; end
      default: begin w_digit = i_digits[15:12]; o_an = 4'b0111; end
    endcase
  end

  // Decimal point sits after the seconds and minutes digits (odd selects)
  assign o_dp  = ~w_sel[0];
  assign o_seg = bcd_to_seg(w_digit);

endmodule

`default_nettype wire

// File: rtl/stopwatch_lap_timer.sv
// ============================================================================
// Module  : stopwatch_lap_timer
// Brief   : M:SS.t stopwatch with lap hold; count-down under STOPWATCH_COUNTDOWN_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 10,
  parameter int MUX_BITS = 18,
  parameter int MAX_MIN  = 9
) (
  input wire logic              clk,
  input wire logic              rst,
  stopwatch_lap_timer_if.slave  bus
);

  localparam int         DIV    = CLK_HZ / TICK_HZ;
  localparam int         DIV_W  = $clog2(DIV);
  localparam logic [3:0] D3_MAX = 4'(MAX_MIN);

  sw_state_e        r_state, w_state_nxt;
  logic             r_ss_q, r_lap_q, w_ss_ev, w_lap_ev;
  logic [DIV_W-1:0] r_div;
  logic             w_counting, w_tick;
  logic [3:0]       r_d0, r_d1, r_d2, r_d3;
  logic [15:0]      w_live, r_hold;
  logic             r_overflow, r_running, r_lap_active;

  assign w_live     = {r_d3, r_d2, r_d1, r_d0};
  assign w_ss_ev    = bus.start_stop & ~r_ss_q;
  assign w_lap_ev   = bus.lap & ~r_lap_q;
  assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_tick     = w_counting && (r_div == DIV_W'(DIV - 1));

`ifdef STOPWATCH_COUNTDOWN_EN
  logic        r_down, r_done;
  logic [15:0] w_preset_cl;
  logic        w_reach_zero;

  assign w_preset_cl  = {clamp_digit(bus.preset[15:12], D3_MAX),
                         clamp_digit(bus.preset[11:8],  D2_MAX),
                         clamp_digit(bus.preset[7:4],   D1_MAX),
                         clamp_digit(bus.preset[3:0],   D0_MAX)};
  assign w_reach_zero = w_tick && r_down && (w_live == 16'h0001);

  always_ff @(posedge clk) begin
    if (rst)                     r_down <= 1'b0;
    else if (r_state == ST_IDLE) r_down <= bus.mode_down;
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, bus.mode_down, bus.preset};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_q  <= 1'b0;
      r_lap_q <= 1'b0;
    end else begin
      r_ss_q  <= bus.start_stop;
      r_lap_q <= bus.lap;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_ss_ev) begin
`ifdef STOPWATCH_COUNTDOWN_EN
          w_state_nxt = (bus.mode_down && w_preset_cl == 16'h0000) ? ST_DONE : ST_RUN;
`else
          w_state_nxt = ST_RUN;
`endif
        end
        ST_RUN:   if (w_ss_ev) w_state_nxt = ST_PAUSE; else if (w_lap_ev) w_state_nxt = ST_LAP;
        ST_LAP:   if (w_ss_ev) w_state_nxt = ST_PAUSE; else if (w_lap_ev) w_state_nxt = ST_RUN;
        ST_PAUSE: if (w_ss_ev) w_state_nxt = ST_RUN;
        default:  w_state_nxt = r_state;
      endcase
`ifdef STOPWATCH_COUNTDOWN_EN
      // Reaching zero outranks any button event landing on the same tick
      if (w_reach_zero) w_state_nxt = ST_DONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
      r_done       <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_running    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAP);
      r_lap_active <= (w_state_nxt == ST_LAP);
`ifdef STOPWATCH_COUNTDOWN_EN
      r_done       <= (w_state_nxt == ST_DONE);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear || r_state == ST_IDLE) r_div <= '0;
    else if (w_counting)                         r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      {r_d3, r_d2, r_d1, r_d0} <= 16'h0000;
      r_overflow               <= 1'b0;
    end else if (r_state == ST_IDLE) begin
`ifdef STOPWATCH_COUNTDOWN_EN
      {r_d3, r_d2, r_d1, r_d0} <= bus.mode_down ? w_preset_cl : 16'h0000;
`else
      {r_d3, r_d2, r_d1, r_d0} <= 16'h0000;
`endif
`ifdef STOPWATCH_COUNTDOWN_EN
    end else if (w_tick && r_down) begin
      r_d0 <= (r_d0 != 4'd0) ? r_d0 - 4'd1 : D0_MAX;
      if (r_d0 == 4'd0) begin
        r_d1 <= (r_d1 != 4'd0) ? r_d1 - 4'd1 : D1_MAX;
        if (r_d1 == 4'd0) begin
          r_d2 <= (r_d2 != 4'd0) ? r_d2 - 4'd1 : D2_MAX;
          if (r_d2 == 4'd0) r_d3 <= (r_d3 != 4'd0) ? r_d3 - 4'd1 : D3_MAX;
        end
      end
`endif
    end else if (w_tick) begin
      r_d0 <= (r_d0 != D0_MAX) ? r_d0 + 4'd1 : 4'd0;
      if (r_d0 == D0_MAX) begin
        r_d1 <= (r_d1 != D1_MAX) ? r_d1 + 4'd1 : 4'd0;
        if (r_d1 == D1_MAX) begin
          r_d2 <= (r_d2 != D2_MAX) ? r_d2 + 4'd1 : 4'd0;
          if (r_d2 == D2_MAX) begin
            r_d3 <= (r_d3 != D3_MAX) ? r_d3 + 4'd1 : 4'd0;
            if (r_d3 == D3_MAX) r_overflow <= 1'b1;
          end
        end
      end
    end
  end

  // Snapshot the pre-tick count on the RUN->LAP transition only
  always_ff @(posedge clk) begin
    if (rst)                                             r_hold <= 16'h0000;
    else if (r_state == ST_RUN && w_state_nxt == ST_LAP) r_hold <= w_live;
  end

  sw_seg7_mux #(
    .MUX_BITS (MUX_BITS)
  ) u_mux (
    .clk      (clk),
    .rst      (rst),
    .i_digits (r_lap_active ? r_hold : w_live),
    .o_seg    (bus.seg),
    .o_dp     (bus.dp),
    .o_an     (bus.an)
  );

  assign bus.time_bcd   = w_live;
  assign bus.running    = r_running;
  assign bus.lap_active = r_lap_active;
  assign bus.overflow   = r_overflow;
`ifdef STOPWATCH_COUNTDOWN_EN
  assign bus.done       = r_done;
`else
  assign bus.done       = 1'b0;
`endif

endmodule

`default_nettype wire
